// File: rtl/sum_accumulator_if.sv
// Handshake bundle between the adder result stream, the accumulator and the next stage.
// The master drives start/len/din/in_valid/out_ready; the accumulator is the slave.
interface sum_accumulator_if #(
    parameter int DIN_W = 16,
    parameter int ACC_W = 20,
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] len;
    logic [DIN_W-1:0] din;
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] acc_out;
    logic             out_valid;
    logic             out_ready;
    logic             ovf;
    logic             busy;

    modport master (
        output start, len, din, in_valid, out_ready,
        input  in_ready, acc_out, out_valid, ovf, busy
    );

    modport slave (
        input  start, len, din, in_valid, out_ready,
        output in_ready, acc_out, out_valid, ovf, busy
    );
endinterface

// File: rtl/sum_accumulator.sv
// Accumulates a programmed number of unsigned adder results into a wider sum with a
// sticky carry-out flag; all outputs are registered and depend only on stored state.
module sum_accumulator #(
    parameter int DIN_W = 16,
    parameter int ACC_W = 20,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                sclrn,
    sum_accumulator_if.slave    bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_remaining;
    logic [ACC_W-1:0]   r_acc_out;
    logic               r_out_valid;
    logic               r_in_ready;
    logic               r_ovf;
    logic               r_busy;

    logic [ACC_W:0]     w_sum;
    logic               w_accept;

    // One extra bit captures the carry out of the accumulator MSB.
    assign w_sum    = {1'b0, r_acc} + {{(ACC_W + 1 - DIN_W){1'b0}}, bus.din};
    assign w_accept = bus.in_valid & r_in_ready;

    always_ff @(posedge clk or negedge sclrn) begin
        if (!sclrn) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_remaining <= '0;
            r_acc_out   <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
            r_ovf       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_ovf  <= 1'b0;
                        r_acc  <= '0;
                        r_busy <= 1'b1;
                        if (bus.len != '0) begin
                            r_remaining <= bus.len;
                            r_in_ready  <= 1'b1;
                            r_state     <= S_ACCUM;
                        end else begin
                            r_acc_out   <= '0;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        r_acc       <= w_sum[ACC_W-1:0];
                        r_remaining <= r_remaining - 1'b1;
                        if (w_sum[ACC_W]) begin
                            r_ovf <= 1'b1;
                        end
                        if (r_remaining == CNT_W'(1)) begin
                            r_acc_out   <= w_sum[ACC_W-1:0];
                            r_out_valid <= 1'b1;
                            r_in_ready  <= 1'b0;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.acc_out   = r_acc_out;
    assign bus.out_valid = r_out_valid;
    assign bus.ovf       = r_ovf;
    assign bus.busy      = r_busy;
endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
- Downstream stage of the 8-bit operand adder; consumes its 16-bit result stream.
- Accumulates a programmed number of adder results into a wider running sum.
- Presents the final total to the next stage with a valid/ready handshake and a sticky overflow flag.
- Used for multi-operand sums and checksum-style reductions in the datapath.

Parameters:
- DIN_W, 16, width of the incoming adder result.
- ACC_W, 20, accumulator and result width (ACC_W > DIN_W).
- CNT_W, 8, width of the sample-count field len.

Ports:
- clk  input  1  system clock, rising edge.
- sclrn  input  1  reset, asynchronous, active-low.
- start  input  1  begin a new accumulation; sampled only in IDLE.
- len  input  CNT_W  number of samples to accumulate; latched on accepted start.
- din  input  DIN_W  adder result, unsigned.
- in_valid  input  1  din is valid this cycle.
- in_ready  output  1  block accepts din this cycle.
- acc_out  output  ACC_W  final accumulated sum.
- out_valid  output  1  acc_out and ovf are valid.
- out_ready  input  1  downstream accepts the result.
- ovf  output  1  sticky carry-out of the accumulator for the current run.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (sclrn low, asynchronous, no clock edge needed):
  - state = IDLE.
  - acc, remaining, acc_out, ovf, out_valid, in_ready and busy all = 0.
  - Reset asserted mid-operation aborts the run. No out_valid is produced for the aborted run.
- All registered updates occur on the rising edge of clk while sclrn is high.
- States: IDLE, ACCUM, DONE. busy is registered and equals (state != IDLE).
- IDLE:
  - in_ready = 0; in_valid is ignored.
  - On start = 1: ovf cleared and acc cleared.
  - If len != 0: remaining = len, next state ACCUM.
  - If len == 0: acc_out = 0, out_valid = 1, next state DONE.
- ACCUM:
  - in_ready = 1.
  - A sample is accepted when in_valid && in_ready.
  - On each accept: acc = (acc + zero-extended din) mod 2^ACC_W; ovf set if carry-out of bit ACC_W-1; remaining decrements.
  - Cycles with in_valid low are bubbles: acc and remaining hold.
  - On the accept where remaining == 1: acc_out = final sum, out_valid = 1, in_ready = 0, next state DONE.
  - Latency: out_valid is high on the cycle following the last accept.
  - start is ignored.
- DONE:
  - acc_out, ovf and out_valid are held stable until out_valid && out_ready.
  - On that handshake edge: out_valid = 0, next state IDLE. acc_out and ovf keep their values until the next accepted start.
  - start asserted in DONE, including on the handshake cycle, is ignored. A new start is accepted one cycle later, in IDLE.
- ovf is sticky within a run: once set, it stays set until the next accepted start or reset.
- in_ready is a registered output and depends only on state; there is no combinational path from in_valid or out_ready to any output.

Test Plan:
- Async reset: run started, sclrn dropped between clock edges -> acc_out, out_valid, ovf, busy and in_ready go to 0 immediately, with no clk edge.
- Basic run: start with len=3, din = 0x0004, 0x0008, 0xFFFF -> acc_out = 0x1000B, ovf = 0. out_valid rises one cycle after the third accept.
- Overflow wrap: len=17, din = 0xFFFF every cycle -> acc_out = 0x0FFEF (1114095 mod 2^20), ovf = 1.
- Backpressure and bubbles: len=2 with in_valid low for 3 cycles between samples 5 and 6, out_ready held low 5 cycles, start pulsed during DONE -> acc_out = 0x0000B stable throughout, start ignored. IDLE is reached one cycle after out_ready rises.
- Zero length: start with len=0 -> out_valid = 1 and acc_out = 0 on the next cycle; ACCUM is never entered and in_ready stays 0.
- Reset mid-ACCUM: len=4, reset after 2 accepts, then start len=1 with din=0x0007 -> no result from the aborted run; new run gives acc_out = 0x00007, ovf = 0.
